// File: rtl/vending_pkg.sv
// Shared types and defaults for the vending controller: FSM state encoding,
// the default product/price configuration and a price-table lookup helper.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } vend_state_e;

  localparam int DEF_NUM_PROD = 4;
  localparam int DEF_CRED_W   = 6;
  // Product 0 sits in the LSBs: prices are 5, 10, 15, 20 for products 0..3.
  localparam logic [DEF_NUM_PROD*DEF_CRED_W-1:0] DEF_PRICES = {6'd20, 6'd15, 6'd10, 6'd5};

  // Widest price table the lookup helper accepts (NUM_PROD*CRED_W bits).
  localparam int PTBL_MAX_W = 512;

  function automatic logic [31:0] price_lookup(input logic [PTBL_MAX_W-1:0] tbl,
                                               input int cred_w, input int idx);
    logic [31:0] mask;
    mask = (32'd1 << cred_w) - 32'd1;
    return 32'(tbl >> (idx * cred_w)) & mask;
  endfunction

endpackage

// File: rtl/vending_ctrl_if.sv
// Coin/selection/dispenser signal bundle. master drives the front-end inputs,
// slave is the controller side.
interface vending_ctrl_if import vending_pkg::*; #(
  parameter int NUM_PROD = DEF_NUM_PROD,
  parameter int CRED_W   = DEF_CRED_W
);
  localparam int SEL_W = $clog2(NUM_PROD);

  logic                coin_valid;
  logic [CRED_W-1:0]   coin_value;
  logic                sel_valid;
  logic [SEL_W-1:0]    sel_id;
  logic                cancel;
  logic [NUM_PROD-1:0] stock_empty;
  logic                vend_ready;
  logic                vend_valid;
  logic [SEL_W-1:0]    vend_id;
  logic                change_valid;
  logic [CRED_W-1:0]   change_amt;
  logic [CRED_W-1:0]   credit;
  logic                coin_reject;
  logic                sel_error;

  modport master (
    output coin_valid, coin_value, sel_valid, sel_id, cancel, stock_empty, vend_ready,
    input  vend_valid, vend_id, change_valid, change_amt, credit, coin_reject, sel_error
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_id, cancel, stock_empty, vend_ready,
    output vend_valid, vend_id, change_valid, change_amt, credit, coin_reject, sel_error
  );
endinterface

// File: rtl/vend_timeout_cnt.sv
// Inactivity down-counter: clr reloads LIMIT-1, en counts down, expire_o flags
// the LIMIT-th consecutive enabled cycle without a clear.
module vend_timeout_cnt #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = CNT_W'(LIMIT - 1);
    else if (en_i && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
  end

  assign expire_o = en_i && !clr_i && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/vending_ctrl.sv
// Vending controller: collects coin credit, validates selections against price
// and stock, hands the product to the dispenser, then issues one change strobe.
module vending_ctrl import vending_pkg::*; #(
  parameter int                            NUM_PROD    = DEF_NUM_PROD,
  parameter int                            CRED_W      = DEF_CRED_W,
  parameter logic [NUM_PROD*CRED_W-1:0]    PRICES      = DEF_PRICES,
  parameter int                            MAX_CREDIT  = 60,
  parameter int                            TIMEOUT_CYC = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  vending_ctrl_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_PROD);
  localparam logic [PTBL_MAX_W-1:0] PTBL = PTBL_MAX_W'(PRICES);

  vend_state_e       state_q, state_d;
  logic [CRED_W-1:0] credit_q, credit_d, change_q, change_d, price;
  logic [SEL_W-1:0]  vend_id_q, vend_id_d;
  logic              vend_valid_q, change_valid_q, coin_rej_q, coin_rej_d, sel_err_q, sel_err_d;
  logic [CRED_W:0]   coin_sum;
  logic              coin_ok, sel_ok, strobe, tmo_en, tmo_exp;

  assign price    = CRED_W'(price_lookup(PTBL, CRED_W, int'(bus.sel_id)));
  // One extra bit so a wrapping sum can never sneak under MAX_CREDIT.
  assign coin_sum = {1'b0, credit_q} + {1'b0, bus.coin_value};
  assign coin_ok  = bus.coin_valid && !bus.sel_valid && !bus.cancel &&
                    (coin_sum <= (CRED_W+1)'(MAX_CREDIT)) &&
                    (state_q == ST_IDLE || state_q == ST_COLLECT);
  assign sel_ok   = (int'(bus.sel_id) < NUM_PROD) && !bus.stock_empty[bus.sel_id] &&
                    (credit_q >= price);
  assign strobe   = bus.coin_valid || bus.sel_valid || bus.cancel;
  assign tmo_en   = (state_q == ST_COLLECT);

  vend_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!tmo_en || strobe),
    .en_i     (tmo_en),
    .expire_o (tmo_exp)
  );

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    change_d  = change_q;
    vend_id_d = vend_id_q;
    sel_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (coin_ok) begin
          credit_d = coin_sum[CRED_W-1:0];
          state_d  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (bus.cancel) begin
          change_d = credit_q;
          state_d  = ST_CHANGE;
        end else if (bus.sel_valid) begin
          if (sel_ok) begin
            vend_id_d = bus.sel_id;
            change_d  = credit_q - price;
            state_d   = ST_VEND;
          end else begin
            sel_err_d = 1'b1;
          end
        end else if (coin_ok) begin
          credit_d = coin_sum[CRED_W-1:0];
        end else if (tmo_exp) begin
          change_d = credit_q;
          state_d  = ST_CHANGE;
        end
      end
      ST_VEND:   if (bus.vend_ready) state_d = ST_CHANGE;
      ST_CHANGE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Credit is handed back as change, so it reads zero from the change cycle on.
    if (state_d == ST_CHANGE) credit_d = '0;
    coin_rej_d = bus.coin_valid && !coin_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      change_q       <= '0;
      vend_id_q      <= '0;
      vend_valid_q   <= 1'b0;
      change_valid_q <= 1'b0;
      coin_rej_q     <= 1'b0;
      sel_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_q       <= change_d;
      vend_id_q      <= vend_id_d;
      vend_valid_q   <= (state_d == ST_VEND);
      change_valid_q <= (state_d == ST_CHANGE);
      coin_rej_q     <= coin_rej_d;
      sel_err_q      <= sel_err_d;
    end
  end

  assign bus.vend_valid   = vend_valid_q;
  assign bus.vend_id      = vend_id_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_amt   = change_q;
  assign bus.credit       = credit_q;
  assign bus.coin_reject  = coin_rej_q;
  assign bus.sel_error    = sel_err_q;
endmodule

// File: tb/tb_vending_ctrl.sv
// Randomised scoreboard bench for vending_ctrl: a transaction-level model queues
// the expected per-edge outputs, a negedge monitor pops and compares them.
module tb_vending_ctrl;
  localparam int TO   = 1000;
  localparam int MAXC = 60;
  localparam int M_IDLE = 0, M_COL = 1, M_VEND = 2, M_CHG = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vending_ctrl_if #(.NUM_PROD(4), .CRED_W(6)) bus ();

  vending_ctrl #(.MAX_CREDIT(MAXC), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int e; bit vv; int vid; bit cv; int camt; bit rej; bit serr; int cred;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   ecnt = 0;
  bit   mon_en = 1'b0;
  int   prices [4] = '{5, 10, 15, 20};
  logic [3:0] stock = 4'b0000;

  // Reference model state
  int m_mode = M_IDLE, m_credit = 0, m_idle = 0, m_chg = 0, m_vid = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (mon_en && q.size() > 0 && q[0].e <= ecnt) begin
      x = q.pop_front();
      if (x.e != ecnt) chk("edge_sync", x.e, ecnt);
      chk("vend_valid", int'(bus.vend_valid), int'(x.vv));
      if (x.vv) chk("vend_id", int'(bus.vend_id), x.vid);
      chk("change_valid", int'(bus.change_valid), int'(x.cv));
      if (x.cv) chk("change_amt", int'(bus.change_amt), x.camt);
      chk("coin_reject", int'(bus.coin_reject), int'(x.rej));
      chk("sel_error", int'(bus.sel_error), int'(x.serr));
      chk("credit", int'(bus.credit), x.cred);
    end
  end

  // One clock of stimulus; the model derives what the next edge must show.
  task automatic step(input bit cv, input int cval, input bit sv, input int sid,
                      input bit cn, input bit vr);
    exp_t x;
    bit acc;
    bus.coin_valid  = cv;
    bus.coin_value  = 6'(cval);
    bus.sel_valid   = sv;
    bus.sel_id      = 2'(sid);
    bus.cancel      = cn;
    bus.vend_ready  = vr;
    bus.stock_empty = stock;
    x = '{default: 0};
    x.e = ecnt + 1;
    acc = cv && !sv && !cn && (m_credit + cval <= MAXC) && (m_mode == M_IDLE || m_mode == M_COL);
    x.rej = cv && !acc;
    case (m_mode)
      M_IDLE: if (acc) begin m_credit = cval; m_mode = M_COL; m_idle = 0; end
      M_COL: begin
        if (cn) begin
          m_chg = m_credit; m_mode = M_CHG;
        end else if (sv) begin
          if (m_credit >= prices[sid] && !stock[sid]) begin
            m_vid = sid; m_chg = m_credit - prices[sid]; m_mode = M_VEND;
          end else x.serr = 1'b1;
        end else if (acc) m_credit += cval;
        if (cv || sv || cn) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == TO) begin m_chg = m_credit; m_mode = M_CHG; end
        end
      end
      M_VEND: if (vr) m_mode = M_CHG;
      default: m_mode = M_IDLE;
    endcase
    if (m_mode == M_CHG) m_credit = 0;
    x.vv   = (m_mode == M_VEND);
    x.vid  = m_vid;
    x.cv   = (m_mode == M_CHG);
    x.camt = m_chg;
    x.cred = m_credit;
    q.push_back(x);
    @(posedge clk); #1;
    bus.coin_valid = 1'b0;
    bus.sel_valid  = 1'b0;
    bus.cancel     = 1'b0;
  endtask

  task automatic coin(input int v);    step(1, v, 0, 0, 0, 0); endtask
  task automatic sel(input int id);    step(0, 0, 1, id, 0, 0); endtask
  task automatic cancel_req();         step(0, 0, 0, 0, 1, 0); endtask
  task automatic idle(input int n, input bit vr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, vr);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_vend_valid", int'(bus.vend_valid), 0);
    chk("rst_change_valid", int'(bus.change_valid), 0);
    chk("rst_coin_reject", int'(bus.coin_reject), 0);
    chk("rst_sel_error", int'(bus.sel_error), 0);
    chk("rst_credit", int'(bus.credit), 0);
    chk("rst_change_amt", int'(bus.change_amt), 0);
    chk("rst_vend_id", int'(bus.vend_id), 0);
    q.delete();
    m_mode = M_IDLE; m_credit = 0; m_idle = 0; m_chg = 0; m_vid = 0;
    bus.coin_valid = 1'b0; bus.sel_valid = 1'b0; bus.cancel = 1'b0; bus.vend_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin
    bus.coin_valid = 1'b0; bus.coin_value = '0; bus.sel_valid = 1'b0; bus.sel_id = '0;
    bus.cancel = 1'b0; bus.stock_empty = '0; bus.vend_ready = 1'b0;
    do_reset();

    // 10+10, product 2 (price 15), dispenser ready at once -> change 5
    coin(10); coin(10); sel(2); step(0, 0, 0, 0, 0, 1); idle(2, 0);
    // 5 is short for product 3 (20): selection refused, then refund 5
    coin(5); sel(3); idle(2, 0); cancel_req(); idle(1, 0);
    // 55 + 10 overflows and bounces, +5 lands exactly on the limit, refund 60
    coin(25); coin(20); coin(10); coin(10); coin(5); coin(1); cancel_req(); idle(1, 0);
    // product 1 out of stock; product 0 vends with 15 change
    stock = 4'b0010;
    coin(20); sel(1); sel(0); idle(3, 0); step(0, 0, 0, 0, 0, 1); idle(1, 0);
    stock = 4'b0000;
    // inactivity refund after TO idle cycles
    coin(10); idle(TO + 2, 0);
    // strobes coincident with cancel/selection, then a long-stalled vend with coins
    coin(10); step(1, 5, 0, 0, 1, 0); idle(1, 0);
    coin(20); step(1, 5, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 5, 0, 0, 1, 0);
    do_reset();
    idle(4, 1);

    // randomised traffic
    for (int n = 0; n < 4000; n++) begin
      int  cval;
      bit  cv, sv, cn, vr;
      if (n % 50 == 0) stock = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: cval = 5;
        1: cval = 10;
        2: cval = 20;
        3: cval = 25;
        4: cval = 0;
        default: cval = int'($urandom_range(0, 63));
      endcase
      cv = ($urandom_range(0, 99) < 35);
      sv = ($urandom_range(0, 99) < 12);
      cn = ($urandom_range(0, 99) < 3);
      vr = ($urandom_range(0, 99) < 60);
      step(cv, cval, sv, int'($urandom_range(0, 3)), cn, vr);
    end
    idle(4, 1);

    @(negedge clk); #1;
    chk("pending_expectations", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
